// File: rtl/mdu_wb.sv
// rtl/mdu_wb.sv - iterative RV32M multiply/divide unit driving the register-file write port
module mdu_wb #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            ready,
    output logic [4:0]      busy_rd,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   a_raw_q, a_raw_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d, neg_rem_q, neg_rem_d;
    logic              dz_q, dz_d, ovf_q, ovf_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic              sgn_a, sgn_b, sa, sb, dz_in, ovf_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] acc_init, acc_step;
    logic [XLEN-1:0]   acc_hi, acc_lo, diff;
    logic [XLEN:0]     mul_sum, part;
    logic              ge;

    // Negate by recorded signs, apply the divide special cases, then pick by funct3.
    function automatic logic [XLEN-1:0] pick_result(
        input logic [2:0]        fop,
        input logic [2*XLEN-1:0] acc,
        input logic              neg,
        input logic              neg_rem,
        input logic              dz,
        input logic              ovf,
        input logic [XLEN-1:0]   a_raw
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        logic [XLEN-1:0]   res;
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (dz) begin
            quo = '1;
            rem = a_raw;
        end else if (ovf) begin
            quo = MIN_NEG;
            rem = '0;
        end
        case (fop)
            3'd0:         res = prod[XLEN-1:0];
            3'd4, 3'd5:   res = quo;
            3'd6, 3'd7:   res = rem;
            default:      res = prod[2*XLEN-1:XLEN];
        endcase
        return res;
    endfunction

    // Operand conditioning at accept: magnitudes, sign flags, special-case detection.
    always_comb begin
        sgn_a    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        sgn_b    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        sa       = sgn_a & rs1_val[XLEN-1];
        sb       = sgn_b & rs2_val[XLEN-1];
        mag_a    = sa ? -rs1_val : rs1_val;
        mag_b    = sb ? -rs2_val : rs2_val;
        dz_in    = op[2] && (rs2_val == '0);
        ovf_in   = op[2] && !op[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
        // Low half holds the multiplier (consumed LSB first) or the dividend (MSB first).
        acc_init = {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
    end

    // One iteration: shift-add multiply or restoring divide step on the shared accumulator.
    always_comb begin
        acc_hi   = acc_q[2*XLEN-1:XLEN];
        acc_lo   = acc_q[XLEN-1:0];
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        part     = {acc_hi, acc_lo[XLEN-1]};
        ge       = part >= {1'b0, b_q};
        diff     = part[XLEN-1:0] - b_q;
        acc_step = op_q[2] ? {(ge ? diff : part[XLEN-1:0]), acc_lo[XLEN-2:0], ge}
                           : {mul_sum, acc_lo[XLEN-1:1]};
    end

    // Next-state logic: accept, iterate, flush and writeback staging.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        b_d       = b_q;
        a_raw_d   = a_raw_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d      = op;
                    rd_d      = rd;
                    a_raw_d   = rs1_val;
                    b_d       = op[2] ? mag_b : mag_a;
                    acc_d     = acc_init;
                    neg_d     = sa ^ sb;
                    neg_rem_d = sa;
                    dz_d      = dz_in;
                    ovf_d     = ovf_in;
                    cnt_d     = '0;
                    if (EARLY_OUT && (dz_in || ovf_in)) begin
                        state_d   = DONE;
                        wb_we_d   = (rd != 5'd0);
                        wb_rd_d   = rd;
                        wb_data_d = pick_result(op, acc_init, sa ^ sb, sa, dz_in, ovf_in, rs1_val);
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d   = DONE;
                        wb_we_d   = (rd_q != 5'd0);
                        wb_rd_d   = rd_q;
                        wb_data_d = pick_result(op_q, acc_step, neg_q, neg_rem_q, dz_q, ovf_q, a_raw_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            b_q       <= '0;
            a_raw_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            b_q       <= b_d;
            a_raw_q   <= a_raw_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy_rd = (state_q == IDLE) ? 5'd0 : rd_q;
    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
endmodule

// File: doc/mdu_wb.md
Name: mdu_wb

Overview:
- Iterative RV32M multiply/divide unit that feeds the register file write port (a3/wd3/we3) directly.
- Decode hands it an M-extension operation with operands already read from the register file. It computes over about 32 cycles, then emits a one-cycle writeback.
- While it is busy it exports the pending destination register, so decode can stall on RAW hazards against the in-flight result.

Parameters:
- XLEN, 32, operand/result width; the counter is $clog2(XLEN)+1 bits.
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow skip CALC and go straight to DONE.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; accepted only when ready=1
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_val  in  XLEN  operand A (dividend / multiplicand)
- rs2_val  in  XLEN  operand B (divisor / multiplier)
- rd  in  5  destination register
- flush  in  1  abort the in-flight operation, with no writeback
- ready  out  1  idle and able to accept start
- busy_rd  out  5  rd of the in-flight op; 0 when idle
- wb_we  out  1  write enable to the register file (we3)
- wb_rd  out  5  write address (a3)
- wb_data  out  XLEN  write data (wd3)

Behaviour:
- Reset (rst_n=0 at a clk edge), required outputs: state=IDLE, ready=1, busy_rd=0, wb_we=0, wb_rd=0, wb_data=0. Reset overrides flush, start and any operation in progress.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 latches op, rd and the operands, clears cnt, and goes to CALC.
  - With EARLY_OUT=1 and (divisor==0, or signed DIV/REM with A=0x80000000 and B=0xFFFFFFFF), it goes to DONE instead.
  - ready=1 only in IDLE.
- Operand conditioning at accept:
  - Signed operands are converted to magnitude (MUL* signed per op: MULH both, MULHSU A only, MUL/MULHU none). DIV/REM are signed; DIVU/REMU are not.
  - Sign flags are recorded: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
- CALC multiply: shift-add over a 2*XLEN accumulator, one multiplier bit per cycle, LSB first.
- CALC divide: restoring division, one quotient bit per cycle, MSB first; partial remainder is XLEN+1 bits.
- CALC length: exactly XLEN cycles. Transition to DONE when cnt reaches XLEN-1.
- Result selection, in the cycle of entering DONE:
  - Results are conditionally negated, then selected.
  - MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].
  - DIV/DIVU return the quotient. REM/REMU return the remainder.
- Special results (regardless of EARLY_OUT):
  - Divide by zero: quotient = 0xFFFFFFFF and remainder = A, for both signed and unsigned.
  - Overflow (-2^31 / -1): quotient = 0x80000000, remainder = 0.
- DONE lasts one cycle, with registered outputs:
  - wb_we=1 if latched rd != 0, else wb_we=0.
  - wb_rd and wb_data are valid in the same cycle.
  - Next state is IDLE.
- Timing:
  - Normal latency: start accepted at edge T0, wb_we high during cycle T0+XLEN+1, ready again at T0+XLEN+2.
  - Early-out latency: wb_we high during cycle T0+1.
- Outside DONE, wb_we=0. wb_rd and wb_data hold their last values and carry no meaning.
- busy_rd = latched rd in CALC and DONE, 0 in IDLE. Decode compares it against its rs1/rs2 for stalls.
- start while ready=0 is ignored: no latch, no error.
- flush=1 in CALC returns to IDLE next cycle, with no wb_we.
- flush=1 in DONE does not suppress the writeback, because that instruction has already committed.
- flush=1 and start=1 together in IDLE: flush wins and nothing is accepted.
- Back-to-back operation: a new start is accepted in the IDLE cycle immediately after DONE. There is no overlap.

Test Plan:
- MUL 7 * -3 (rs2=0xFFFFFFFD), rd=5 -> wb_we=1 exactly 33 cycles after accept, wb_rd=5, wb_data=0xFFFFFFEB; ready stays 0 throughout.
- MULH/MULHSU/MULHU with A=0x80000000, B=0xFFFFFFFF -> 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV -7/2 -> quotient 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. With EARLY_OUT=1, wb_we arrives at accept+1.
- flush at cycle 10 of CALC -> no wb_we, ready=1 next cycle. A start while busy is ignored. rd=0 -> the op completes with wb_we=0.
- rst_n low at cycle 15 of CALC -> next cycle: ready=1, busy_rd=0, wb_we=0, and no later writeback.
